fifo_sync_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the synchronous LSRAM FIFO RAM wrapper. It owns the write and read pointers, the occupancy count and the status flags. It gates the user write and read strobes into RAM write and read enables, and it tracks RAM read latency so a data-valid strobe can be issued. It sits between the user logic and the RAM wrapper in the single-clock (SYNC=1) FIFO configuration.

---
 rtl/fifo_ctrl_pkg.sv | 23 ++
 rtl/fifo_ptr_cnt.sv | 43 ++++
 rtl/fifo_sync_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the single-clock FIFO controller slice.
//   cnt_width()     : width of the occupancy counter for a given address
//                     width (one extra bit so that a full FIFO, D entries,
//                     is representable next to an empty one).
//   ram_lat_legal() : the RAM wrapper supports only a non-pipelined
//                     (1 cycle) or pipelined (2 cycle) read path.
// ---------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int unsigned RAM_LAT_NONPIPE = 1;
  localparam int unsigned RAM_LAT_PIPE    = 2;

  function automatic int unsigned cnt_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit ram_lat_legal(input int unsigned lat);
    return (lat == RAM_LAT_NONPIPE) || (lat == RAM_LAT_PIPE);
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// ---------------------------------------------------------------------------
// fifo_ptr_cnt
// Wrapping ADDR_W-bit FIFO pointer. Advances by one on every enabled cycle
// and wraps from 2**ADDR_W-1 back to 0 through natural binary overflow.
//
// Ports
//   clk_i    in   rising-edge clock
//   rst_n_i  in   asynchronous active-low reset, pointer returns to 0
//   en_i     in   advance the pointer at the next edge
//   ptr_o    out  current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr_cnt
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_sync_ctrl
// Single-clock FIFO controller sitting between user logic and the LSRAM
// FIFO RAM wrapper (the wrapper itself is instantiated one level up).
// Owns the write/read pointers, occupancy count and status flags, gates the
// user strobes into RAM enables and delays accepted reads by the RAM read
// latency to produce a data-valid strobe.
//
// Parameters
//   WIDTH      data width (matches RAM wrapper RWIDTH/WWIDTH)
//   ADDR_W     address width, depth D = 2**ADDR_W
//   RAM_LAT    RAM read latency, 1 (non-pipelined) or 2 (pipelined)
//   AFULL_TH   AFULL when COUNT >= AFULL_TH
//   AEMPTY_TH  AEMPTY when COUNT <= AEMPTY_TH
//
// Ports
//   CLOCK, RESET_N           clock, asynchronous active-low reset
//   WE, WDATA                user write request and data
//   RE                       user read request
//   RDATA, DVLD              read data (from RAM) and its valid strobe
//   FULL, EMPTY, AFULL,
//   AEMPTY, COUNT            registered status, reflect accesses up to the
//                            previous edge
//   OVERFLOW, UNDERFLOW      one-cycle pulses for rejected accesses
//   RAM_WEN, RAM_WADDR,
//   RAM_WDATA                RAM write port
//   RAM_REN, RAM_RADDR,
//   RAM_RDATA                RAM read port
// ---------------------------------------------------------------------------
module fifo_sync_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned AFULL_TH  = 120,
  parameter int unsigned AEMPTY_TH = 8
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic              RE,
  output logic [WIDTH-1:0]  RDATA,
  output logic              DVLD,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic              RAM_WEN,
  output logic              RAM_REN,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [ADDR_W-1:0] RAM_RADDR,
  output logic [WIDTH-1:0]  RAM_WDATA,
  input  logic [WIDTH-1:0]  RAM_RDATA
);

  localparam int unsigned CW = cnt_width(ADDR_W);
  localparam logic [CW-1:0] DEPTH_C  = CW'(2 ** ADDR_W);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  if (!ram_lat_legal(RAM_LAT)) begin : g_bad_ram_lat
    $error("fifo_sync_ctrl: RAM_LAT must be 1 or 2");
  end

  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               afull_q, afull_d;
  logic               aempty_q, aempty_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [RAM_LAT-1:0] lat_q, lat_d;

  // RESET_N in the gate keeps the RAM idle while reset is held: FULL is 0
  // in reset and would otherwise let a write strobe through.
  assign wr_acc = WE & ~full_q  & RESET_N;
  assign rd_acc = RE & ~empty_q & RESET_N;

  fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_wptr (
    .clk_i   (CLOCK),
    .rst_n_i (RESET_N),
    .en_i    (wr_acc),
    .ptr_o   (wptr)
  );

  fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_rptr (
    .clk_i   (CLOCK),
    .rst_n_i (RESET_N),
    .en_i    (rd_acc),
    .ptr_o   (rptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are looked up from the next count so they are exact the cycle
    // after the access, with no extra lag.
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    // A rejected access still reports even if the opposite side was accepted.
    ovf_d = WE & full_q;
    unf_d = RE & empty_q;

    // Shift accepted reads through RAM_LAT stages; bit 0 is the newest read.
    lat_d = RAM_LAT'({lat_q, rd_acc});
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      lat_q    <= '0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      lat_q    <= lat_d;
    end
  end

  assign RAM_WEN   = wr_acc;
  assign RAM_REN   = rd_acc;
  assign RAM_WADDR = wptr;
  assign RAM_RADDR = rptr;
  assign RAM_WDATA = WDATA;

  assign RDATA     = RAM_RDATA;
  assign DVLD      = lat_q[RAM_LAT-1];

  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

  localparam int D = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  // Instance 1: RAM_LAT = 1
  logic [31:0] rdata1, ramw1, ramr1;
  logic        dvld1, full1, empty1, afull1, aempty1, ovf1, unf1, wen1, ren1;
  logic [7:0]  count1;
  logic [6:0]  waddr1, raddr1;

  // Instance 2: RAM_LAT = 2
  logic [31:0] rdata2, ramw2, ramr2;
  logic        dvld2, full2, empty2, afull2, aempty2, ovf2, unf2, wen2, ren2;
  logic [7:0]  count2;
  logic [6:0]  waddr2, raddr2;

  fifo_sync_ctrl #(.WIDTH(32), .ADDR_W(7), .RAM_LAT(1), .AFULL_TH(120), .AEMPTY_TH(8)) u_l1 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we), .WDATA(wdata), .RE(re),
    .RDATA(rdata1), .DVLD(dvld1), .FULL(full1), .EMPTY(empty1), .AFULL(afull1),
    .AEMPTY(aempty1), .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(unf1),
    .RAM_WEN(wen1), .RAM_REN(ren1), .RAM_WADDR(waddr1), .RAM_RADDR(raddr1),
    .RAM_WDATA(ramw1), .RAM_RDATA(ramr1)
  );

  fifo_sync_ctrl #(.WIDTH(32), .ADDR_W(7), .RAM_LAT(2), .AFULL_TH(120), .AEMPTY_TH(8)) u_l2 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we), .WDATA(wdata), .RE(re),
    .RDATA(rdata2), .DVLD(dvld2), .FULL(full2), .EMPTY(empty2), .AFULL(afull2),
    .AEMPTY(aempty2), .COUNT(count2), .OVERFLOW(ovf2), .UNDERFLOW(unf2),
    .RAM_WEN(wen2), .RAM_REN(ren2), .RAM_WADDR(waddr2), .RAM_RADDR(raddr2),
    .RAM_WDATA(ramw2), .RAM_RDATA(ramr2)
  );

  // RAM wrapper models: 1-cycle registered read, and 2-cycle pipelined read.
  logic [31:0] mem1 [D];
  logic [31:0] mem2 [D];
  logic [31:0] st2;

  always @(posedge clk) begin
    if (wen1) mem1[waddr1] <= ramw1;
    if (ren1) ramr1 <= mem1[raddr1];
    if (wen2) mem2[waddr2] <= ramw2;
    if (ren2) st2 <= mem2[raddr2];
    ramr2 <= st2;
  end

  // Reference FIFO model, advanced by the stimulus tasks at each edge.
  int          m_cnt, m_wp, m_rp;
  logic [31:0] m_q[$];
  bit          m_ovf, m_unf, m_v1, m_va, m_vb;
  logic [31:0] m_d1, m_da, m_db;

  int n_checks = 0;
  int n_errors = 0;
  bit obs_wen1, obs_ren1, obs_wen2, obs_ren2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_q.delete();
    m_ovf = 0; m_unf = 0; m_v1 = 0; m_va = 0; m_vb = 0;
    m_d1 = '0; m_da = '0; m_db = '0;
  endtask

  task automatic model_edge();
    bit          wr_ok, rd_ok;
    logic [31:0] rd_v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr_ok = we && (m_cnt < D);
    rd_ok = re && (m_cnt > 0);
    rd_v  = rd_ok ? m_q.pop_front() : 32'h0;
    if (wr_ok) begin m_q.push_back(wdata); m_wp = (m_wp + 1) % D; end
    if (rd_ok) m_rp = (m_rp + 1) % D;
    m_ovf = we && (m_cnt == D);
    m_unf = re && (m_cnt == 0);
    m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    m_vb = m_va; m_db = m_da;
    m_va = rd_ok; m_da = rd_v;
    m_v1 = rd_ok; m_d1 = rd_v;
  endtask

  task automatic check_state();
    chk("l1_count",  32'(count1),  32'(m_cnt));
    chk("l2_count",  32'(count2),  32'(m_cnt));
    chk("l1_full",   32'(full1),   32'(m_cnt == D));
    chk("l2_full",   32'(full2),   32'(m_cnt == D));
    chk("l1_empty",  32'(empty1),  32'(m_cnt == 0));
    chk("l2_empty",  32'(empty2),  32'(m_cnt == 0));
    chk("l1_afull",  32'(afull1),  32'(m_cnt >= 120));
    chk("l1_aempty", 32'(aempty1), 32'(m_cnt <= 8));
    chk("l2_afull",  32'(afull2),  32'(m_cnt >= 120));
    chk("l2_aempty", 32'(aempty2), 32'(m_cnt <= 8));
    chk("l1_ovf",    32'(ovf1),    32'(m_ovf));
    chk("l1_unf",    32'(unf1),    32'(m_unf));
    chk("l2_ovf",    32'(ovf2),    32'(m_ovf));
    chk("l2_unf",    32'(unf2),    32'(m_unf));
    chk("l1_dvld",   32'(dvld1),   32'(m_v1));
    chk("l2_dvld",   32'(dvld2),   32'(m_vb));
    if (m_v1) chk("l1_rdata", rdata1, m_d1);
    if (m_vb) chk("l2_rdata", rdata2, m_db);
  endtask

  task automatic check_comb();
    bit ew, er;
    ew = rst_n && we && (m_cnt < D);
    er = rst_n && re && (m_cnt > 0);
    obs_wen1 = wen1; obs_ren1 = ren1; obs_wen2 = wen2; obs_ren2 = ren2;
    chk("l1_ram_wen", 32'(wen1), 32'(ew));
    chk("l1_ram_ren", 32'(ren1), 32'(er));
    chk("l2_ram_wen", 32'(wen2), 32'(ew));
    chk("l2_ram_ren", 32'(ren2), 32'(er));
    chk("l1_waddr",   32'(waddr1), 32'(m_wp));
    chk("l1_raddr",   32'(raddr1), 32'(m_rp));
    chk("l2_waddr",   32'(waddr2), 32'(m_wp));
    chk("l2_raddr",   32'(raddr2), 32'(m_rp));
    chk("l1_ram_wdata", ramw1, wdata);
  endtask

  // One clock of stimulus: check state left by the last edge, drive, check
  // the combinational enables, then let the edge happen.
  task automatic step(input bit w, input bit r, input logic [31:0] d);
    @(negedge clk);
    check_state();
    we = w; re = r; wdata = d;
    #1 check_comb();
    @(posedge clk);
    model_edge();
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] wd;
    bit          wen;
    bit          ren;
    int          cnt;
    bit          empty;
    bit          unf;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int wr_done, guard;
    bit w, r;

    vecs[0] = '{we:0, re:0, wd:32'h0,  wen:0, ren:0, cnt:0, empty:1, unf:0};
    vecs[1] = '{we:0, re:1, wd:32'h0,  wen:0, ren:0, cnt:0, empty:1, unf:1};
    vecs[2] = '{we:1, re:0, wd:32'hA1, wen:1, ren:0, cnt:1, empty:0, unf:0};
    vecs[3] = '{we:1, re:1, wd:32'hA2, wen:1, ren:1, cnt:1, empty:0, unf:0};
    vecs[4] = '{we:1, re:0, wd:32'hA3, wen:1, ren:0, cnt:2, empty:0, unf:0};
    vecs[5] = '{we:0, re:1, wd:32'h0,  wen:0, ren:1, cnt:1, empty:0, unf:0};
    vecs[6] = '{we:0, re:1, wd:32'h0,  wen:0, ren:1, cnt:0, empty:1, unf:0};
    vecs[7] = '{we:1, re:1, wd:32'hA4, wen:1, ren:0, cnt:1, empty:0, unf:1};
    vecs[8] = '{we:0, re:1, wd:32'h0,  wen:0, ren:1, cnt:0, empty:1, unf:0};
    vecs[9] = '{we:0, re:0, wd:32'h0,  wen:0, ren:0, cnt:0, empty:1, unf:0};

    rst_n = 0; we = 0; re = 0; wdata = '0;
    model_reset();

    // Reset and idle; WE held high in reset must not reach the RAM.
    step(1, 0, 32'h55);
    chk("rst_wen_gated", 32'(obs_wen1), 32'h0);
    step(0, 0, 32'h0);
    #1;
    chk("rst_empty",  32'(empty1),  32'h1);
    chk("rst_aempty", 32'(aempty1), 32'h1);
    chk("rst_full",   32'(full1),   32'h0);
    chk("rst_count",  32'(count2),  32'h0);
    @(negedge clk) rst_n = 1;
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);

    // Table of short vectors with hand-computed results.
    foreach (vecs[i]) begin
      @(negedge clk);
      check_state();
      we = vecs[i].we; re = vecs[i].re; wdata = vecs[i].wd;
      #1 check_comb();
      chk($sformatf("vec%0d_wen", i), 32'(wen1), 32'(vecs[i].wen));
      chk($sformatf("vec%0d_ren", i), 32'(ren2), 32'(vecs[i].ren));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count1), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty2), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_unf", i),   32'(unf1),   32'(vecs[i].unf));
    end

    // Fill 1..128, AFULL at the 120th write, FULL at the 128th.
    for (int i = 1; i <= D; i++) begin
      step(1, 0, 32'(i));
      #1;
      if (i == 119) chk("afull_119", 32'(afull1), 32'h0);
      if (i == 120) chk("afull_120", 32'(afull2), 32'h1);
    end
    chk("fill_full",  32'(full1),  32'h1);
    chk("fill_count", 32'(count2), 32'd128);
    step(1, 0, 32'h999);
    chk("ovf_wen", 32'(obs_wen1), 32'h0);
    #1;
    chk("ovf_pulse", 32'(ovf2),   32'h1);
    chk("ovf_count", 32'(count1), 32'd128);
    step(0, 0, 32'h0);
    #1 chk("ovf_one_cycle", 32'(ovf1), 32'h0);

    // Drain: latency-1 data right after each read edge, latency-2 one later.
    for (int i = 1; i <= D; i++) begin
      step(0, 1, 32'h0);
      #1;
      chk("drain_l1_dvld",  32'(dvld1), 32'h1);
      chk("drain_l1_rdata", rdata1,     32'(i));
      if (i >= 2) chk("drain_l2_rdata", rdata2, 32'(i - 1));
    end
    step(0, 0, 32'h0);
    #1;
    chk("drain_l2_last_dvld", 32'(dvld2), 32'h1);
    chk("drain_l2_last",      rdata2,     32'd128);
    chk("drain_l1_idle",      32'(dvld1), 32'h0);
    chk("drain_empty",        32'(empty1), 32'h1);
    step(0, 1, 32'h0);
    #1;
    chk("unf_l1", 32'(unf1), 32'h1);
    chk("unf_l2", 32'(unf2), 32'h1);

    // Wrap-around traffic with random gaps; model tracks the data order.
    wr_done = 0; guard = 0;
    while ((wr_done < 300 || m_cnt > 0) && guard < 5000) begin
      w = (wr_done < 300) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0) || (wr_done >= 300);
      if (w && m_cnt < D) begin
        step(1, r, 32'h1000 + 32'(wr_done));
        wr_done++;
      end else begin
        step(w, r, 32'hDEAD);
      end
      guard++;
    end
    chk("wrap_writes", 32'(wr_done), 32'd300);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    #1 chk("wrap_empty", 32'(empty2), 32'h1);

    // Concurrent read and write at COUNT = 5.
    for (int i = 0; i < 5; i++) step(1, 0, 32'h2000 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'h3000 + 32'(i));
      chk("simul_wen", 32'(obs_wen1), 32'h1);
      chk("simul_ren", 32'(obs_ren2), 32'h1);
      #1;
      chk("simul_count_l1", 32'(count1), 32'd5);
      chk("simul_count_l2", 32'(count2), 32'd5);
    end

    // Reset at COUNT = 50 with a read in flight.
    for (int i = 0; i < 45; i++) step(1, 0, 32'h4000 + 32'(i));
    step(0, 0, 32'h0);
    #1 chk("pre_rst_count", 32'(count1), 32'd50);
    step(0, 1, 32'h0);
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_count", 32'(count1), 32'h0);
    chk("mid_rst_empty", 32'(empty2), 32'h1);
    chk("mid_rst_aempty", 32'(aempty1), 32'h1);
    chk("mid_rst_dvld1", 32'(dvld1),  32'h0);
    chk("mid_rst_dvld2", 32'(dvld2),  32'h0);
    step(0, 0, 32'h0);
    #1 chk("mid_rst_no_dvld2", 32'(dvld2), 32'h0);
    step(0, 0, 32'h0);
    @(negedge clk) rst_n = 1;
    step(1, 0, 32'hCAFE);
    step(0, 1, 32'h0);
    #1;
    chk("post_rst_l1_dvld",  32'(dvld1), 32'h1);
    chk("post_rst_l1_rdata", rdata1,     32'hCAFE);
    step(0, 0, 32'h0);
    #1;
    chk("post_rst_l2_dvld",  32'(dvld2), 32'h1);
    chk("post_rst_l2_rdata", rdata2,     32'hCAFE);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
